// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a host and serial_adder.
// Latency: none, plain wires; timing is set by the adder.
// Backpressure: none; the host issues start only when busy is low.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub select line.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, ci, sub, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, ci, sub, output busy, done, sum, co, ovf);
`else
    modport master (output start, a, b, ci, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, ci, output busy, done, sum, co, ovf);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add processed DIGIT bits per clock via a registered inter-digit carry.
// Latency: N+1 cycles from the start edge to done (N = WIDTH/DIGIT); one result per N+1 cycles.
// Backpressure: none; start is ignored while busy, the host waits for the done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub select (a - b).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // A DIGIT that does not tile WIDTH would leave a partial top digit.
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_co;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_dsum;
    logic [DIGIT:0]   w_c;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_init_carry;

`ifdef SERIAL_ADDER_SUB_EN
    logic r_sub;

    // Subtraction is a + ~b + 1: invert each B digit and seed the carry with 1.
    assign w_b_dig      = r_b[DIGIT-1:0] ^ {DIGIT{r_sub}};
    assign w_init_carry = bus.sub ? 1'b1 : bus.ci;
`else
    assign w_b_dig      = r_b[DIGIT-1:0];
    assign w_init_carry = bus.ci;
`endif

    // Ripple of DIGIT full-adder cells fed by the carry registered from the previous digit.
    always_comb begin
        w_c    = '0;
        w_dsum = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_dsum[i]  = r_a[i] ^ w_b_dig[i] ^ w_c[i];
            w_c[i + 1] = (r_a[i] & w_b_dig[i]) | (w_c[i] & (r_a[i] ^ w_b_dig[i]));
        end
    end

    // New digit enters at the MSB end; after N steps the LSB digit has reached bit 0.
    assign w_acc_next = WIDTH'({w_dsum, r_acc} >> DIGIT);

    // Control FSM and datapath; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= w_init_carry;
                        r_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        r_sub   <= bus.sub;
`endif
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_acc   <= w_acc_next;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Final digit holds the MSB, so its top two carries give signed overflow.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_acc_next;
                        r_co    <= w_c[DIGIT];
                        r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT-1];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.co   = r_co;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for three serial_adder configurations (8/1, 8/4, 2/1).
// Latency: checks done arrives N+1 cycles after the start edge with busy high in between.
// Backpressure: start issued only in IDLE/DONE, except one deliberate start while running.
module tb_serial_adder;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(8)) if84 ();
    serial_adder_if #(.WIDTH(2)) if2 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_add8  (.clk(clk), .reset(reset), .bus(if8.slave));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_add84 (.clk(clk), .reset(reset), .bus(if84.slave));
    serial_adder #(.WIDTH(2), .DIGIT(1)) u_add2  (.clk(clk), .reset(reset), .bus(if2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation on the DIGIT=1 adder; returns at the done sample.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] prev, input logic [7:0] es, input logic eco,
                       input logic eov);
        int   cyc;
        logic busy_ok;
        if8.a     = a;
        if8.b     = b;
        if8.ci    = ci;
        if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        if8.a     = ~a;
        if8.b     = ~b;
        if8.ci    = ~ci;
        cyc       = 1;
        busy_ok   = 1'b1;
        while (if8.done !== 1'b1 && cyc <= 20) begin
            if (if8.busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == 4) check({tag, "_hold"}, 32'(if8.sum), 32'(prev));
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, 9);
        check({tag, "_busy"}, 32'(busy_ok), 1);
        check({tag, "_busy_at_done"}, 32'(if8.busy), 0);
        check({tag, "_res"}, {22'd0, if8.ovf, if8.co, if8.sum}, {22'd0, eov, eco, es});
    endtask

    initial begin
        int ndone;
        int cyc;

        reset      = 1'b1;
        if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.ci  = 1'b0;
        if84.start = 1'b0; if84.a = '0; if84.b = '0; if84.ci = 1'b0;
        if2.start  = 1'b0; if2.a  = '0; if2.b  = '0; if2.ci  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub = 1'b0; if84.sub = 1'b0; if2.sub = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(if8.busy), 0);
        check("rst_done", 32'(if8.done), 0);
        check("rst_sum",  32'(if8.sum),  0);
        check("rst_co",   32'(if8.co),   0);
        check("rst_ovf",  32'(if8.ovf),  0);

        // Start while running is ignored: one done, result of the first operands only.
        if8.a = 8'h01; if8.b = 8'h02; if8.ci = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        if8.a = 8'h33; if8.b = 8'h44; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (if8.done === 1'b1) begin
                ndone++;
                check("ign_sum", 32'(if8.sum), 32'h03);
            end
            tick();
        end
        check("ign_ndone", ndone, 1);
        check("ign_idle", 32'(if8.busy), 0);
        check("ign_hold", 32'(if8.sum), 32'h03);

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
        tick();
        check("pulse_done", 32'(if8.done), 0);
        check("pulse_busy", 32'(if8.busy), 0);
        check("pulse_hold", 32'(if8.sum), 32'h00);

        op8("7f_01", 8'h7F, 8'h01, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
        op8("b2b",   8'h10, 8'h20, 1'b1, 8'h80, 8'h31, 1'b0, 1'b0);
        op8("90_90", 8'h90, 8'h90, 1'b0, 8'h31, 8'h20, 1'b1, 1'b1);

        // Reset in mid-run clears results and discards the operation.
        if8.a = 8'h01; if8.b = 8'h01; if8.ci = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(if8.busy), 0);
        check("mrst_done", 32'(if8.done), 0);
        check("mrst_res", {22'd0, if8.ovf, if8.co, if8.sum}, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (if8.done === 1'b1) ndone++;
            tick();
        end
        check("mrst_nodone", ndone, 0);

        // DIGIT=4: two steps, done three cycles after the start edge.
        if84.a = 8'hA5; if84.b = 8'h5A; if84.ci = 1'b1; if84.start = 1'b1;
        tick();
        if84.start = 1'b0;
        cyc = 1;
        while (if84.done !== 1'b1 && cyc <= 20) begin
            tick();
            cyc++;
        end
        check("d4_lat", cyc, 3);
        check("d4_res", {22'd0, if84.ovf, if84.co, if84.sum}, {22'd0, 1'b0, 1'b1, 8'h00});

        // WIDTH=2 exhaustive, back-to-back.
        for (int v = 0; v < 32; v++) begin
            logic [1:0] a2;
            logic [1:0] b2;
            logic       c2;
            logic [2:0] tot;
            logic       ov;
            a2  = v[1:0];
            b2  = v[3:2];
            c2  = v[4];
            tot = {1'b0, a2} + {1'b0, b2} + {2'b00, c2};
            ov  = (a2[1] == b2[1]) && (tot[1] != a2[1]);
            if2.a = a2; if2.b = b2; if2.ci = c2; if2.start = 1'b1;
            tick();
            if2.start = 1'b0;
            cyc = 1;
            while (if2.done !== 1'b1 && cyc <= 10) begin
                tick();
                cyc++;
            end
            check($sformatf("w2_lat_%0d", v), cyc, 3);
            check($sformatf("w2_res_%0d", v), {28'd0, if2.ovf, if2.co, if2.sum},
                  {28'd0, ov, tot});
        end

`ifdef SERIAL_ADDER_SUB_EN
        if8.sub = 1'b1;
        op8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'h00, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'hFE, 8'h7F, 1'b1, 1'b1);
        if8.sub = 1'b0;
        op8("sub_off",   8'h05, 8'h07, 1'b0, 8'h7F, 8'h0C, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
